// File: rtl/conv_window_addr_gen_pkg.sv
// Shared types and elaboration-time helpers for the convolution window address generator.
package conv_window_addr_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of window origins along one axis for a given stride (0 behaves as 1).
  function automatic int unsigned win_count(input int unsigned img, input int unsigned k,
                                            input int unsigned s);
    int unsigned s_eff;
    s_eff = (s == 0) ? 1 : s;
    return (img - k) / s_eff + 1;
  endfunction

endpackage

// File: rtl/conv_window_addr_gen_wrap_counter.sv
// Wrapping counter with runtime limit; exposes its next value so the parent can register
// derived outputs on the same edge the count moves.
module conv_window_addr_gen_wrap_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_next,
  output logic         o_carry
);

  logic [W-1:0] r_count;

  always_comb begin
    o_carry = i_en & (r_count == i_max);
    if (i_clr) begin
      o_next = '0;
    end else if (o_carry) begin
      o_next = '0;
    end else if (i_en) begin
      o_next = r_count + W'(1);
    end else begin
      o_next = r_count;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_next;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks every KxK window of an IMG_W x IMG_H word image at a runtime stride, issuing one
// read address per valid/ready handshake.
module conv_window_addr_gen
  import conv_window_addr_gen_pkg::*;
#(
  parameter int unsigned AW    = 9,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned K     = 4,
  parameter int unsigned WORD  = 4,
  parameter int unsigned PW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic [1:0]    i_stride,
  output logic          o_addr_valid,
  input  logic          i_addr_ready,
  output logic [AW-1:0] o_addr,
  output logic          o_win_first,
  output logic          o_win_last,
  output logic [PW-1:0] o_pos_x,
  output logic [PW-1:0] o_pos_y,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned KW = cnt_width(K);

  localparam logic [PW-1:0] MaxX1 = PW'(win_count(IMG_W, K, 1) - 1);
  localparam logic [PW-1:0] MaxX2 = PW'(win_count(IMG_W, K, 2) - 1);
  localparam logic [PW-1:0] MaxX3 = PW'(win_count(IMG_W, K, 3) - 1);
  localparam logic [PW-1:0] MaxY1 = PW'(win_count(IMG_H, K, 1) - 1);
  localparam logic [PW-1:0] MaxY2 = PW'(win_count(IMG_H, K, 2) - 1);
  localparam logic [PW-1:0] MaxY3 = PW'(win_count(IMG_H, K, 3) - 1);

  state_e r_state, w_state_d;

  logic [AW-1:0] r_base;
  logic [1:0]    r_s;
  logic [PW-1:0] r_max_x, r_max_y;
  logic [1:0]    w_s_eff;
  logic [PW-1:0] w_max_x_sel, w_max_y_sel;

  logic [AW-1:0] r_addr, w_addr_d;
  logic          r_valid, w_valid_d;
  logic          r_first, w_first_d;
  logic          r_last, w_last_d;
  logic          r_busy, w_busy_d;
  logic          r_done, w_done_d;
  logic [PW-1:0] r_pos_x, r_pos_y;

  logic          w_start_acc, w_xfer, w_walk_end;
  logic [KW-1:0] w_kx_next, w_ky_next;
  logic [PW-1:0] w_px_next, w_py_next;
  logic          w_kx_carry, w_ky_carry, w_px_carry, w_py_carry;
  logic [AW-1:0] w_row, w_elem;

  assign w_start_acc = (r_state == StIdle) & i_start;
  assign w_xfer      = r_valid & i_addr_ready;
  assign w_walk_end  = w_py_carry;
  assign w_s_eff     = (i_stride == 2'd0) ? 2'd1 : i_stride;

  always_comb begin
    unique case (w_s_eff)
      2'd2: begin
        w_max_x_sel = MaxX2;
        w_max_y_sel = MaxY2;
      end
      2'd3: begin
        w_max_x_sel = MaxX3;
        w_max_y_sel = MaxY3;
      end
      default: begin
        w_max_x_sel = MaxX1;
        w_max_y_sel = MaxY1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_base  <= '0;
      r_s     <= 2'd1;
      r_max_x <= '0;
      r_max_y <= '0;
    end else if (w_start_acc) begin
      r_base  <= i_base_addr;
      r_s     <= w_s_eff;
      r_max_x <= w_max_x_sel;
      r_max_y <= w_max_y_sel;
    end
  end

  // Carry chain: kx fastest, then ky, pos_x, pos_y.
  conv_window_addr_gen_wrap_counter #(.W(KW)) u_kx (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_en    (w_xfer),
    .i_max   (KW'(K - 1)),
    .o_next  (w_kx_next),
    .o_carry (w_kx_carry)
  );

  conv_window_addr_gen_wrap_counter #(.W(KW)) u_ky (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_en    (w_kx_carry),
    .i_max   (KW'(K - 1)),
    .o_next  (w_ky_next),
    .o_carry (w_ky_carry)
  );

  conv_window_addr_gen_wrap_counter #(.W(PW)) u_px (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_en    (w_ky_carry),
    .i_max   (r_max_x),
    .o_next  (w_px_next),
    .o_carry (w_px_carry)
  );

  conv_window_addr_gen_wrap_counter #(.W(PW)) u_py (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_acc),
    .i_en    (w_px_carry),
    .i_max   (r_max_y),
    .o_next  (w_py_next),
    .o_carry (w_py_carry)
  );

  // Address of the element the counters are about to point at; wraps silently mod 2^AW.
  assign w_row  = AW'(w_py_next) * AW'(r_s) + AW'(w_ky_next);
  assign w_elem = w_row * AW'(IMG_W) + AW'(w_px_next) * AW'(r_s) + AW'(w_kx_next);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = StRun;
      StRun:   if (w_walk_end) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_addr_d  = r_addr;
    w_first_d = r_first;
    w_last_d  = r_last;
    w_valid_d = (w_state_d == StRun);
    w_busy_d  = (w_state_d != StIdle);
    w_done_d  = (w_state_d == StDone);
    if (w_start_acc) begin
      w_addr_d  = i_base_addr;
      w_first_d = 1'b1;
      w_last_d  = (K == 1);
    end else if (w_walk_end) begin
      w_addr_d  = r_base;
      w_first_d = 1'b0;
      w_last_d  = 1'b0;
    end else if (w_xfer) begin
      w_addr_d  = r_base + w_elem * AW'(WORD);
      w_first_d = (w_kx_next == '0) && (w_ky_next == '0);
      w_last_d  = (w_kx_next == KW'(K - 1)) && (w_ky_next == KW'(K - 1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      r_addr  <= w_addr_d;
      r_valid <= w_valid_d;
      r_first <= w_first_d;
      r_last  <= w_last_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_pos_x <= w_px_next;
      r_pos_y <= w_py_next;
    end
  end

  assign o_addr       = r_addr;
  assign o_addr_valid = r_valid;
  assign o_win_first  = r_first;
  assign o_win_last   = r_last;
  assign o_pos_x      = r_pos_x;
  assign o_pos_y      = r_pos_y;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Randomised-backpressure bench for conv_window_addr_gen against a nested-loop window model.
module tb_conv_window_addr_gen;

  localparam int AW = 9, IMG_W = 8, IMG_H = 8, K = 2, WORD = 4, PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [1:0]    stride;
  logic          addr_valid, addr_ready;
  logic [AW-1:0] addr;
  logic          win_first, win_last, busy, done;
  logic [PW-1:0] pos_x, pos_y;

  conv_window_addr_gen #(
    .AW(AW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .WORD(WORD), .PW(PW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (start),
    .i_base_addr  (base_addr),
    .i_stride     (stride),
    .o_addr_valid (addr_valid),
    .i_addr_ready (addr_ready),
    .o_addr       (addr),
    .o_win_first  (win_first),
    .o_win_last   (win_last),
    .o_pos_x      (pos_x),
    .o_pos_y      (pos_y),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int e_addr[$], e_first[$], e_last[$], e_px[$], e_py[$];
  int got[$], seq1[$];
  int idx = 0, done_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_model(input int base, input int strd);
    int s, ow, oh;
    s  = (strd == 0) ? 1 : strd;
    ow = (IMG_W - K) / s + 1;
    oh = (IMG_H - K) / s + 1;
    e_addr.delete(); e_first.delete(); e_last.delete(); e_px.delete(); e_py.delete();
    for (int py = 0; py < oh; py++)
      for (int px = 0; px < ow; px++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            e_addr.push_back((base + ((py * s + ky) * IMG_W + px * s + kx) * WORD) % (1 << AW));
            e_first.push_back((kx == 0 && ky == 0) ? 1 : 0);
            e_last.push_back((kx == K - 1 && ky == K - 1) ? 1 : 0);
            e_px.push_back(px);
            e_py.push_back(py);
          end
  endtask

  // Compare process: every valid cycle must present the model's next element.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (done) done_cnt++;
      if (addr_valid) begin
        if (idx >= e_addr.size()) begin
          chk("extra_valid", 32'(addr_valid), 32'd0);
        end else begin
          chk("addr", 32'(addr), 32'(e_addr[idx]));
          chk("win_first", 32'(win_first), 32'(e_first[idx]));
          chk("win_last", 32'(win_last), 32'(e_last[idx]));
          chk("pos_x", 32'(pos_x), 32'(e_px[idx]));
          chk("pos_y", 32'(pos_y), 32'(e_py[idx]));
          if (addr_ready) begin
            got.push_back(int'(addr));
            idx++;
          end
        end
      end
    end
  end

  task automatic start_walk(input int base, input int strd, input bit rnd);
    build_model(base, strd);
    idx = 0;
    done_cnt = 0;
    got.delete();
    chk_en = 1'b1;
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = AW'(base);
    stride     = 2'(strd);
    addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until `stop_at` transfers have completed, leaving time at the edge after the last one.
  task automatic drive_until(input int stop_at, input bit rnd, input bit poke);
    int n;
    n = 0;
    while (idx < stop_at && n < 3000) begin
      @(posedge clk); #1;
      n++;
      addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = poke && (n == 20);
      base_addr  = (poke && n == 20) ? AW'(100) : base_addr;
    end
    start = 1'b0;
    if (n >= 3000) chk("walk_timeout", 32'(idx), 32'(stop_at));
  endtask

  task automatic run_walk(input int base, input int strd, input bit rnd, input bit poke);
    start_walk(base, strd, rnd);
    drive_until(e_addr.size(), rnd, poke);
    chk("done_after_last", 32'(done), 32'd1);
    chk("valid_drop", 32'(addr_valid), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd1);
    start = 1'b1;  // must not be captured in DONE
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("idle_not_restarted", 32'(addr_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("xfer_count", 32'(got.size()), 32'(e_addr.size()));
    chk_en = 1'b0;
  endtask

  initial begin
    int nmis;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    stride = 2'd1;
    addr_ready = 1'b1;
    #23;
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pos", 32'({pos_x, pos_y}), 32'd0);
    rst_n = 1'b1;

    run_walk(0, 1, 1'b0, 1'b0);
    chk("s1_total", 32'(got.size()), 32'd196);
    chk("s1_a0", 32'(got[0]), 32'd0);
    chk("s1_a1", 32'(got[1]), 32'd4);
    chk("s1_a2", 32'(got[2]), 32'd32);
    chk("s1_a3", 32'(got[3]), 32'd36);
    seq1 = got;

    run_walk(0, 2, 1'b0, 1'b0);
    chk("s2_total", 32'(got.size()), 32'd64);
    chk("s2_win2", 32'(got[4]), 32'd8);
    chk("s2_lastwin", 32'(got[60]), 32'd216);
    chk("s2_final", 32'(got[63]), 32'd252);

    run_walk(0, 0, 1'b0, 1'b0);
    nmis = 0;
    for (int i = 0; i < seq1.size(); i++) if (i >= got.size() || got[i] != seq1[i]) nmis++;
    chk("s0_eq_s1", 32'(nmis), 32'd0);

    run_walk(500, 1, 1'b0, 1'b0);
    chk("wrap_a0", 32'(got[0]), 32'd500);
    chk("wrap_a1", 32'(got[1]), 32'd504);
    chk("wrap_a2", 32'(got[2]), 32'd20);
    chk("wrap_a3", 32'(got[3]), 32'd24);

    run_walk(0, 1, 1'b1, 1'b1);
    nmis = 0;
    for (int i = 0; i < seq1.size(); i++) if (i >= got.size() || got[i] != seq1[i]) nmis++;
    chk("bp_eq_s1", 32'(nmis), 32'd0);

    // Abort mid-walk.
    start_walk(40, 1, 1'b0);
    drive_until(10, 1'b0, 1'b0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(addr_valid), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_flags", 32'({win_first, win_last}), 32'd0);
    chk("abort_pos", 32'({pos_x, pos_y}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    nmis = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) nmis++;
    end
    chk("abort_no_done", 32'(nmis), 32'd0);
    rst_n = 1'b1;
    run_walk(40, 1, 1'b0, 1'b0);
    chk("restart_base", 32'(got[0]), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
